// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use stall, redirect flush.
// Optional saturating stall/flush performance counters under HAZARD_PERF_CNT_EN.

module hazard_fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic [1:0]            sel
);
  // M is younger than W, so it wins; x0 is never a real producer.
  always_comb begin
    sel = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e))      sel = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) sel = 2'b01;
  end
endmodule

module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D_i,
  input  logic [REG_ADDR_W-1:0] Rs2D_i,
  input  logic [REG_ADDR_W-1:0] RdD_i,
  input  logic                  RegWriteD_i,
  input  logic                  LoadD_i,
  input  logic                  RedirectE_i,
  output logic [1:0]            ForwardAEctrl_o,
  output logic [1:0]            ForwardBEctrl_o,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [CNT_W-1:0]      StallCnt_o,
  output logic [CNT_W-1:0]      FlushCnt_o
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  load;
  } e_ent_t;

  // The load flag is dropped once past E: nothing downstream of E consults it.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } mw_ent_t;

  e_ent_t  e_q;
  mw_ent_t m_q, w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
      w_q <= m_q;
      if (FlushE_o) e_q <= '0;
      else          e_q <= '{rs1: Rs1D_i, rs2: Rs2D_i, rd: RdD_i,
                             reg_write: RegWriteD_i, load: LoadD_i};
    end
  end

  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] rs_e;
  logic [NUM_SRC-1:0][1:0]            fwd_sel;

  assign rs_e = {e_q.rs2, e_q.rs1};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs_e        (rs_e[s]),
      .rd_m        (m_q.rd),
      .reg_write_m (m_q.reg_write),
      .rd_w        (w_q.rd),
      .reg_write_w (w_q.reg_write),
      .sel         (fwd_sel[s])
    );
  end

  logic lu;
  assign lu = e_q.load && e_q.reg_write && (e_q.rd != '0) &&
              ((e_q.rd == Rs1D_i) || (e_q.rd == Rs2D_i));

  // Redirect beats load-use: the stalled D instruction is on the wrong path anyway.
  always_comb begin
    ForwardAEctrl_o = fwd_sel[0];
    ForwardBEctrl_o = fwd_sel[1];
    StallF_o        = lu && !RedirectE_i;
    StallD_o        = lu && !RedirectE_i;
    FlushD_o        = RedirectE_i;
    FlushE_o        = lu || RedirectE_i;
    if (rst) begin
      ForwardAEctrl_o = 2'b00;
      ForwardBEctrl_o = 2'b00;
      StallF_o        = 1'b0;
      StallD_o        = 1'b0;
      FlushD_o        = 1'b0;
      FlushE_o        = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (FlushD_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`else
  assign StallCnt_o = '0;
  assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction-history model checked every cycle plus literal pins.
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1d = 5'd5, rs2d = 5'd0, rdd = 5'd5;
  logic        wrd = 1'b1, ldd = 1'b1, redir = 1'b1;
  logic [1:0]  fa, fb;
  logic        sf, sd, fd, fe;
  logic [31:0] scnt, fcnt;

  int n_chk = 0;
  int n_pass = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .RdD_i(rdd),
    .RegWriteD_i(wrd), .LoadD_i(ldd), .RedirectE_i(redir),
    .ForwardAEctrl_o(fa), .ForwardBEctrl_o(fb),
    .StallF_o(sf), .StallD_o(sd), .FlushD_o(fd), .FlushE_o(fe),
    .StallCnt_o(scnt), .FlushCnt_o(fcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       wr, ld;
  } ins_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } exp_t;

  // Instruction history in E/M/W order: hist[2] is in E, hist[1] in M, hist[0] in W.
  ins_t hist[$];
  int   stall_cnt_m = 0;
  int   flush_cnt_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    ins_t p;
    for (int age = 1; age <= 2; age++) begin
      p = hist[2-age];
      if (p.wr && p.rd != 0 && p.rd == rs) return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t x;
    ins_t e;
    logic lu;
    x = '0;
    if (rst || hist.size() != 3) return x;
    e    = hist[2];
    lu   = e.ld && e.wr && e.rd != 0 && (e.rd == rs1d || e.rd == rs2d);
    x.fa = m_fwd(e.rs1);
    x.fb = m_fwd(e.rs2);
    x.sf = lu && !redir;
    x.sd = lu && !redir;
    x.fd = redir;
    x.fe = lu || redir;
    return x;
  endfunction

  task automatic model_step();
    exp_t x;
    ins_t d;
    if (rst) begin
      hist = {};
      repeat (3) hist.push_back(ins_t'(0));
      stall_cnt_m = 0;
      flush_cnt_m = 0;
    end else if (hist.size() == 3) begin
      x = model();
      if (x.sd) stall_cnt_m++;
      if (x.fd) flush_cnt_m++;
      d = '{rs1: rs1d, rs2: rs2d, rd: rdd, wr: wrd, ld: ldd};
      hist.push_back(x.fe ? ins_t'(0) : d);
      void'(hist.pop_front());
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle compare against the history model.
  initial forever begin
    exp_t x;
    @(negedge clk);
    x = model();
    chk("cyc_fwdA", {30'd0, fa}, {30'd0, x.fa});
    chk("cyc_fwdB", {30'd0, fb}, {30'd0, x.fb});
    chk("cyc_stallF", {31'd0, sf}, {31'd0, x.sf});
    chk("cyc_stallD", {31'd0, sd}, {31'd0, x.sd});
    chk("cyc_flushD", {31'd0, fd}, {31'd0, x.fd});
    chk("cyc_flushE", {31'd0, fe}, {31'd0, x.fe});
`ifdef HAZARD_PERF_CNT_EN
    chk("cyc_scnt", scnt, stall_cnt_m);
    chk("cyc_fcnt", fcnt, flush_cnt_m);
`else
    chk("cyc_scnt", scnt, 32'd0);
    chk("cyc_fcnt", fcnt, 32'd0);
`endif
  end

  task automatic drv(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic w, input logic l, input logic r);
    @(posedge clk);
    #1;
    rs1d = a; rs2d = b; rdd = d; wrd = w; ldd = l; redir = r;
  endtask

  task automatic nop();
    drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit_all0(input string nm);
    chk({nm, "_fa"}, {30'd0, fa}, 32'd0);
    chk({nm, "_fb"}, {30'd0, fb}, 32'd0);
    chk({nm, "_sf"}, {31'd0, sf}, 32'd0);
    chk({nm, "_sd"}, {31'd0, sd}, 32'd0);
    chk({nm, "_fd"}, {31'd0, fd}, 32'd0);
    chk({nm, "_fe"}, {31'd0, fe}, 32'd0);
  endtask

  initial begin
    #2 lit_all0("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rs1d = 0; rs2d = 0; rdd = 0; wrd = 0; ldd = 0; redir = 0;

    // add x5,x1,x2 then a consumer of x5 in rs1
    drv(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    drv(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
    nop(); #1;
    chk("fwdM_A", {30'd0, fa}, 32'd2);
    chk("fwdM_B", {30'd0, fb}, 32'd0);
    nop();

    // two writers of x7, consumer reads x7 on both sources
    drv(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    drv(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
    drv(5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0);
    nop(); #1;
    chk("MoverW_A", {30'd0, fa}, 32'd2);
    chk("MoverW_B", {30'd0, fb}, 32'd2);

    // only the older writer of x7
    drv(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    drv(5'd1, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0);
    drv(5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    nop(); #1;
    chk("fwdW_A", {30'd0, fa}, 32'd0);
    chk("fwdW_B", {30'd0, fb}, 32'd1);

    // x0 writer never forwards, even to an x0 source
    drv(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    drv(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    nop(); #1;
    chk("x0_A", {30'd0, fa}, 32'd0);
    chk("x0_B", {30'd0, fb}, 32'd0);

    // lw x3 then consumer with rs2=x3: one-cycle stall, then W forward
    drv(5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    drv(5'd4, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_sf", {31'd0, sf}, 32'd1);
    chk("lu_sd", {31'd0, sd}, 32'd1);
    chk("lu_fe", {31'd0, fe}, 32'd1);
    chk("lu_fd", {31'd0, fd}, 32'd0);
    drv(5'd4, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_once_sd", {31'd0, sd}, 32'd0);
    nop(); #1;
    chk("lu_fwdW_B", {30'd0, fb}, 32'd1);

    // redirect flushes the would-be consumer out of E
    drv(5'd1, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0);
    drv(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1); #1;
    chk("rd_fd", {31'd0, fd}, 32'd1);
    chk("rd_fe", {31'd0, fe}, 32'd1);
    chk("rd_sf", {31'd0, sf}, 32'd0);
    nop(); #1;
    chk("rd_bubble_A", {30'd0, fa}, 32'd0);

    // load-use and redirect together
    drv(5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    drv(5'd3, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1); #1;
    chk("sim_sf", {31'd0, sf}, 32'd0);
    chk("sim_fd", {31'd0, fd}, 32'd1);
    chk("sim_fe", {31'd0, fe}, 32'd1);
    nop();

    // async reset while a stall is active
    drv(5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    drv(5'd3, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0); #1;
    chk("mid_pre_sd", {31'd0, sd}, 32'd1);
    #1 rst = 1'b1;
    #1 lit_all0("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0; #1;
    chk("post_rel_sd", {31'd0, sd}, 32'd0);
    nop();

    // three load-use stalls, two redirects
    repeat (3) begin
      drv(5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      drv(5'd3, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
      drv(5'd3, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
      nop();
    end
    repeat (2) begin
      drv(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      nop();
    end
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_stall", scnt, 32'd3);
    chk("cnt_flush", fcnt, 32'd2);
`else
    chk("cnt_stall", scnt, 32'd0);
    chk("cnt_flush", fcnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
